// File: rtl/line_sequencer.sv
// line_sequencer: steps through a small line memory, presenting one line at a time to a
// downstream consumer and collecting one result per line.
//
// Ports:
//   clk, rst                   single clock; rst is asynchronous, active-low
//   load_en/load_addr/load_data  memory write port, honoured only while idle
//   num_lines                  lines per run (clamped to DEPTH), latched when a run starts
//   start                      level run request, sampled in idle and done
//   dut_done/dut_result        consumer handshake for the line in flight
//   line/new_line/count        registered line to the consumer, its fresh strobe, its index
//   res_valid/res_data/res_index  one-cycle result strobe with data and slot index
//   busy/all_done/timeout_err  run status; timeout_err is sticky for the current run
module line_sequencer #(
  parameter int unsigned LINE_W  = 25,
  parameter int unsigned DEPTH   = 64,
  parameter int unsigned TIMEOUT = 500
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       load_en,
  input  logic [$clog2(DEPTH)-1:0]   load_addr,
  input  logic [LINE_W-1:0]          load_data,
  input  logic [$clog2(DEPTH):0]     num_lines,
  input  logic                       start,
  input  logic                       dut_done,
  input  logic [LINE_W-1:0]          dut_result,
  output logic [LINE_W-1:0]          line,
  output logic                       new_line,
  output logic [$clog2(DEPTH)-1:0]   count,
  output logic                       res_valid,
  output logic [LINE_W-1:0]          res_data,
  output logic [$clog2(DEPTH)-1:0]   res_index,
  output logic                       busy,
  output logic                       all_done,
  output logic                       timeout_err
);

  localparam int unsigned ADDR_W  = $clog2(DEPTH);
  localparam int unsigned TIMER_W = $clog2(TIMEOUT + 1);

  // Timer value seen on the TIMEOUT-th wait cycle (timer starts at 0 on the first one).
  localparam logic [TIMER_W-1:0] TimerLast  = TIMER_W'(TIMEOUT - 1);
  localparam logic [ADDR_W:0]    DepthLines = (ADDR_W + 1)'(DEPTH);
  localparam logic [ADDR_W-1:0]  LastSlot   = ADDR_W'(DEPTH - 1);

  typedef enum logic [2:0] {StIdle, StIssue, StWait, StCapture, StDone} state_e;

  state_e               state_q, state_d;
  logic [ADDR_W-1:0]    count_q, count_d;
  logic [ADDR_W-1:0]    last_q, last_d;       // index of the final line of this run
  logic [TIMER_W-1:0]   timer_q, timer_d;
  logic [LINE_W-1:0]    line_q, line_d;
  logic                 new_line_q, new_line_d;
  logic [LINE_W-1:0]    res_data_q, res_data_d;
  logic [ADDR_W-1:0]    res_index_q, res_index_d;
  logic                 timeout_err_q, timeout_err_d;

  // Line storage; deliberately not reset so loaded contents survive a reset.
  logic [LINE_W-1:0]    mem [DEPTH];

  always_ff @(posedge clk) begin
    if (load_en && (state_q == StIdle)) begin
      mem[load_addr] <= load_data;
    end
  end

  always_comb begin
    state_d       = state_q;
    count_d       = count_q;
    last_d        = last_q;
    timer_d       = timer_q;
    line_d        = line_q;
    new_line_d    = 1'b0;
    res_data_d    = res_data_q;
    res_index_d   = res_index_q;
    timeout_err_d = timeout_err_q;

    unique case (state_q)
      StIdle: begin
        if (start && (num_lines != '0)) begin
          state_d       = StIssue;
          count_d       = '0;
          timeout_err_d = 1'b0;
          last_d        = (num_lines > DepthLines) ? LastSlot : ADDR_W'(num_lines - 1'b1);
        end
      end
      StIssue: begin
        // new_line is registered so it rises together with the freshly loaded line.
        line_d     = mem[count_q];
        new_line_d = 1'b1;
        timer_d    = '0;
        state_d    = StWait;
      end
      StWait: begin
        // dut_done is checked first so a response on the expiry cycle still wins.
        if (dut_done) begin
          res_data_d  = dut_result;
          res_index_d = count_q;
          state_d     = StCapture;
        end else if (timer_q == TimerLast) begin
          res_data_d    = {LINE_W{1'b1}};
          res_index_d   = count_q;
          timeout_err_d = 1'b1;
          state_d       = StCapture;
        end else begin
          timer_d = timer_q + 1'b1;
        end
      end
      StCapture: begin
        if (count_q == last_q) begin
          state_d = StDone;
        end else begin
          count_d = count_q + 1'b1;
          state_d = StIssue;
        end
      end
      StDone: begin
        if (!start) begin
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q       <= StIdle;
      count_q       <= '0;
      last_q        <= '0;
      timer_q       <= '0;
      line_q        <= '0;
      new_line_q    <= 1'b0;
      res_data_q    <= '0;
      res_index_q   <= '0;
      timeout_err_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      count_q       <= count_d;
      last_q        <= last_d;
      timer_q       <= timer_d;
      line_q        <= line_d;
      new_line_q    <= new_line_d;
      res_data_q    <= res_data_d;
      res_index_q   <= res_index_d;
      timeout_err_q <= timeout_err_d;
    end
  end

  assign line        = line_q;
  assign new_line    = new_line_q;
  assign count       = count_q;
  assign res_valid   = (state_q == StCapture);
  assign res_data    = res_data_q;
  assign res_index   = res_index_q;
  assign busy        = (state_q == StIssue) || (state_q == StWait) || (state_q == StCapture);
  assign all_done    = (state_q == StDone);
  assign timeout_err = timeout_err_q;

endmodule

// File: tb/tb_line_sequencer.sv
module tb_line_sequencer;

  localparam int LW    = 25;
  localparam int DEPTH = 64;
  localparam int TO    = 8;
  localparam int AW    = 6;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          load_en = 1'b0;
  logic [AW-1:0] load_addr = '0;
  logic [LW-1:0] load_data = '0;
  logic [AW:0]   num_lines = '0;
  logic          start = 1'b0;
  logic          dut_done;
  logic [LW-1:0] dut_result = '0;
  logic [LW-1:0] line;
  logic          new_line;
  logic [AW-1:0] count;
  logic          res_valid;
  logic [LW-1:0] res_data;
  logic [AW-1:0] res_index;
  logic          busy;
  logic          all_done;
  logic          timeout_err;

  logic cons_done = 1'b0;
  logic idle_poke = 1'b0;
  assign dut_done = cons_done | idle_poke;

  line_sequencer #(
    .LINE_W  (LW),
    .DEPTH   (DEPTH),
    .TIMEOUT (TO)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .load_en     (load_en),
    .load_addr   (load_addr),
    .load_data   (load_data),
    .num_lines   (num_lines),
    .start       (start),
    .dut_done    (dut_done),
    .dut_result  (dut_result),
    .line        (line),
    .new_line    (new_line),
    .count       (count),
    .res_valid   (res_valid),
    .res_data    (res_data),
    .res_index   (res_index),
    .busy        (busy),
    .all_done    (all_done),
    .timeout_err (timeout_err)
  );

  always #5 clk = ~clk;

  // delay: cycles after new_line before dut_done; -1 means the consumer never answers.
  typedef struct { int idx; int delay; logic [LW-1:0] line; } plan_t;
  typedef struct { int idx; logic [LW-1:0] data; } exp_t;

  plan_t         plan_q[$];
  exp_t          exp_q[$];
  logic [LW-1:0] model_mem [DEPTH];
  int            n_checks = 0;
  int            n_errors = 0;
  int            n_res    = 0;
  int            last_idx = -1;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Monitor: every result strobe is matched against the oldest expected result.
  always @(negedge clk) begin
    exp_t e;
    if (rst && res_valid) begin
      n_res++;
      last_idx = int'(res_index);
      if (exp_q.size() == 0) begin
        n_checks++;
        n_errors++;
        $display("FAIL unexpected_res_valid: got index %0d data %0h expected no result",
                 res_index, res_data);
      end else begin
        e = exp_q.pop_front();
        check("res_index", 64'(res_index), 64'(e.idx));
        check("res_data", 64'(res_data), 64'(e.data));
      end
    end
  end

  // Consumer model: answers each presented line with line+1 after the planned delay.
  always begin
    plan_t p;
    @(negedge clk);
    if (rst && new_line) begin
      if (plan_q.size() == 0) begin
        n_checks++;
        n_errors++;
        $display("FAIL unexpected_new_line: got count %0d expected no line", count);
      end else begin
        p = plan_q.pop_front();
        check("line", 64'(line), 64'(p.line));
        check("count", 64'(count), 64'(p.idx));
        if (p.delay >= 0) begin
          repeat (p.delay) @(negedge clk);
          cons_done  = 1'b1;
          dut_result = p.line + LW'(1);
          @(negedge clk);
          cons_done  = 1'b0;
          dut_result = LW'($urandom);
        end
      end
    end
  end

  task automatic load(input int a, input logic [LW-1:0] d);
    load_en   = 1'b1;
    load_addr = AW'(a);
    load_data = d;
    @(negedge clk);
    load_en   = 1'b0;
    model_mem[a] = d;
  endtask

  // mode 0 random delays, 1 fixed 5, 2 line 1 silent, 3 answer on expiry cycle,
  // 4 line 0 answers then all silent. abort_line >= 0 resets during that line's wait.
  task automatic do_run(input int nl, input int mode, input bit poke_load, input int abort_line);
    int eff;
    int d;
    int bound;
    int c;
    bit exp_to;
    logic [LW-1:0] data;
    eff    = (nl > DEPTH) ? DEPTH : nl;
    exp_to = 1'b0;
    for (int i = 0; i < eff; i++) begin
      case (mode)
        0:       d = ($urandom_range(0, 5) == 0) ? -1 : int'($urandom_range(0, TO));
        1:       d = 5;
        2:       d = (i == 1) ? -1 : 2;
        3:       d = TO - 1;
        4:       d = (i == 0) ? 1 : -1;
        default: d = 0;
      endcase
      plan_q.push_back('{i, d, model_mem[i]});
      if (d >= 0 && d <= TO - 1) begin
        data = model_mem[i] + LW'(1);
      end else begin
        data   = {LW{1'b1}};
        exp_to = 1'b1;
      end
      exp_q.push_back('{i, data});
    end
    n_res    = 0;
    last_idx = -1;
    bound    = eff * (TO + 4) + 20;

    num_lines = (AW + 1)'(nl);
    start     = 1'b1;
    @(negedge clk);
    check("accept_busy", 64'(busy), 64'd1);
    check("accept_new_line", 64'(new_line), 64'd0);
    num_lines = (AW + 1)'($urandom);
    if (poke_load) begin
      load_en   = 1'b1;
      load_addr = AW'($urandom_range(0, 2));
      load_data = LW'($urandom);
    end
    @(negedge clk);
    load_en = 1'b0;
    check("first_new_line", 64'(new_line), 64'd1);

    if (abort_line >= 0) begin
      c = 0;
      while (c < bound && !(new_line && int'(count) == abort_line)) begin
        @(negedge clk);
        c++;
      end
      check("abort_reached", 64'(c < bound), 64'd1);
      repeat (2) @(negedge clk);
      check("pre_reset_busy", 64'(busy), 64'd1);
      check("pre_reset_timeout_err", 64'(timeout_err), 64'd1);
      #2 rst = 1'b0;
      #1;
      check("rst_busy", 64'(busy), 64'd0);
      check("rst_all_done", 64'(all_done), 64'd0);
      check("rst_new_line", 64'(new_line), 64'd0);
      check("rst_res_valid", 64'(res_valid), 64'd0);
      check("rst_timeout_err", 64'(timeout_err), 64'd0);
      check("rst_count", 64'(count), 64'd0);
      check("rst_line", 64'(line), 64'd0);
      check("rst_res_data", 64'(res_data), 64'd0);
      check("rst_res_index", 64'(res_index), 64'd0);
      check("abort_res_count", 64'(n_res), 64'(abort_line));
      check("abort_pending", 64'(exp_q.size()), 64'(eff - abort_line));
      exp_q.delete();
      plan_q.delete();
      start = 1'b0;
      @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      return;
    end

    c = 0;
    while (c < bound && !all_done) begin
      @(negedge clk);
      c++;
    end
    check("all_done", 64'(all_done), 64'd1);
    check("timeout_err", 64'(timeout_err), 64'(exp_to));
    check("res_count", 64'(n_res), 64'(eff));
    check("last_index", 64'(last_idx), 64'(eff - 1));
    check("scoreboard_empty", 64'(exp_q.size()), 64'd0);
    check("plan_empty", 64'(plan_q.size()), 64'd0);
    if (!all_done) begin
      rst = 1'b0;
      exp_q.delete();
      plan_q.delete();
      @(negedge clk);
      rst = 1'b1;
    end
    @(negedge clk);
    check("done_hold", 64'(all_done), 64'(!busy && all_done));
    start = 1'b0;
    @(negedge clk);
    @(negedge clk);
    check("back_to_idle", 64'({busy, all_done}), 64'd0);
  endtask

  initial begin
    #3 rst = 1'b0;
    #1;
    check("reset_busy", 64'(busy), 64'd0);
    check("reset_all_done", 64'(all_done), 64'd0);
    check("reset_res_valid", 64'(res_valid), 64'd0);
    check("reset_new_line", 64'(new_line), 64'd0);
    check("reset_count", 64'(count), 64'd0);
    check("reset_timeout_err", 64'(timeout_err), 64'd0);
    repeat (2) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);

    for (int i = 0; i < DEPTH; i++) begin
      load(i, (i < 4) ? LW'(i + 1) : LW'($urandom));
    end

    // Basic run: results 2..5, no timeout.
    do_run(4, 1, 1'b0, -1);
    // Silent consumer on line 1, plus a write attempt while busy.
    do_run(3, 2, 1'b1, -1);

    // start with zero lines must leave the sequencer idle; dut_done ignored too.
    num_lines = '0;
    start     = 1'b1;
    idle_poke = 1'b1;
    repeat (3) begin
      @(negedge clk);
      check("zero_lines_busy", 64'(busy), 64'd0);
      check("zero_lines_new_line", 64'(new_line), 64'd0);
    end
    start     = 1'b0;
    idle_poke = 1'b0;
    @(negedge clk);

    // Clamp to DEPTH; also reads back slots targeted by the ignored write.
    do_run(100, 0, 1'b0, -1);
    // Response on the expiry cycle wins over the timeout.
    do_run(5, 3, 1'b0, -1);
    // Reset during the wait of line 2, then restart from index 0 with memory intact.
    do_run(4, 4, 1'b0, 2);
    do_run(4, 0, 1'b0, -1);

    for (int r = 0; r < 6; r++) begin
      for (int k = 0; k < 4; k++) begin
        load(int'($urandom_range(0, DEPTH - 1)), LW'($urandom));
      end
      do_run(int'($urandom_range(1, 127)), 0, 1'(r[0]), -1);
    end

    repeat (3) @(negedge clk);
    check("final_scoreboard_empty", 64'(exp_q.size()), 64'd0);
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout: got no finish expected finish");
    $fatal(1, "simulation time limit");
  end

endmodule
